switches_port: RTL and testbench
================================

# switches_port

Parametrised memory-mapped switch input peripheral on the 8-bit processor bus, serving up to eight switch banks of 8 bits each. Every bank passes through a two-flop synchroniser and a per-byte debouncer. Each committed change sets a sticky flag, and enabled flags raise a bus interrupt with an acknowledge handshake. It sits beside the other bus peripherals and replaces the plain two-byte switch reader.

## Interface
- BASE_ADDR, 8'hE0, first bus address of the register window
- NUM_BYTES, 2, switch banks (1..8); window size is NUM_BYTES+2
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to commit (≥2)
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  shared data bus; driven only for reads of this window, else hi-Z
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  1 = CPU write, 0 = read
- SW  in  8*NUM_BYTES  raw switch pins; byte i = SW[8i+7:8i], asynchronous
- BUS_INTERRUPT_RAISE  out  1  interrupt request
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from the interrupt controller

## Operation
- Register map, offset from BASE_ADDR:
  - i < NUM_BYTES: STABLE[i], read-only; writes ignored.
  - NUM_BYTES: CHANGE, bit i set when byte i commits a new value. Write-1-to-clear. Bits ≥ NUM_BYTES read 0.
  - NUM_BYTES+1: IRQ_EN mask, read/write.
- Synchroniser: two flops per bit, giving the synchronised value S[i].
- Debounce, per byte:
  - The counter clears when S == STABLE, or when S differs from its previous-cycle value.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1, the block sets STABLE <= S, clears the counter and sets CHANGE[i].
- Interrupt FSM, with pending = |(CHANGE & IRQ_EN):
  - IDLE: RAISE=0. Go to REQ if pending.
  - REQ: RAISE=1. Go to SERVICED on ACK.
  - SERVICED: RAISE=0. Go to IDLE when pending==0.
  - While in SERVICED, further changes never re-raise. A change still pending when IDLE is re-entered raises again on the next cycle.
- Simultaneous events: on a clear of CHANGE[i] in the same cycle that byte i commits, the set wins.
- After reset, non-zero switch positions commit as changes once debounced. This is intended: the CPU learns the initial positions this way.
- Reset asserted mid-operation asynchronously clears everything listed below, releases the bus and drops RAISE. Any in-progress debounce is discarded.

## Timing
- Reset values: sync flops 0, STABLE 0, counters 0, CHANGE 0, IRQ_EN 0, bus drive-enable 0 (BUS_DATA hi-Z), BUS_INTERRUPT_RAISE 0, FSM IDLE.
- Read: with an address in the window and BUS_WE=0 at edge N, the output register and drive-enable load at N. Data is valid on BUS_DATA from N until edge N+1, which is one cycle of latency. If the address leaves the window, the bus is released after the next edge.
- Write: captured at the edge where the address matches and BUS_WE=1. The bus is never driven in a write cycle.
- Pin to STABLE, with the macro: 2 sync cycles + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never commits.
- CHANGE is set in the same edge as STABLE. RAISE follows one cycle later, given IRQ_EN.

## Configuration
- SWITCHES_DEBOUNCE_EN defined: debouncer as specified above.
- SWITCHES_DEBOUNCE_EN undefined:
  - No counters exist; DEBOUNCE_CYCLES and CNT_W are unused.
  - STABLE <= S every cycle, and CHANGE[i] sets whenever S != STABLE.
  - Pin-to-STABLE latency is 3 cycles.

## Structure
- Package switches_pkg holds:
  - register offset constants (STABLE base 0; CHANGE and IRQ_EN expressed via NUM_BYTES)
  - the FSM state enum: IDLE, REQ, SERVICED.
- Sub-module switch_debounce covers one byte: synchroniser, counter, STABLE, and a one-cycle commit pulse. It is instantiated NUM_BYTES times by generate. The top level holds CHANGE, IRQ_EN, the bus mux/driver and the FSM.

## Test plan
- Reset with SW=16'hA55A, DEBOUNCE_CYCLES=8: BUS_DATA hi-Z and RAISE=0 during reset. After 2+8 cycles, reading E0 gives 8'h5A, E1 gives 8'hA5, and E2 gives 8'h03.
- A 5-cycle glitch on SW[0] (DEBOUNCE_CYCLES=8): STABLE[0] and CHANGE are unchanged. A 10-cycle hold commits exactly 8 cycles after the synchroniser.
- Write E3<=8'h02, then toggle bank 1: RAISE rises one cycle after commit. ACK drops it. Toggling bank 1 again keeps RAISE low. Writing E2<=8'h02 returns the FSM to IDLE, and it re-raises next cycle because bank 1 changed again.
- Write E2<=8'h01 on the same edge bank 0 commits: CHANGE[0] remains 1.
- Read an out-of-window address (E4 with NUM_BYTES=2) and any write cycle: BUS_DATA stays hi-Z. A read of E3 returns the last IRQ_EN value one cycle after the address.
- Assert RESET mid-debounce and while in REQ: RAISE drops immediately and the bus is released. After release, the count restarts from 0.

Source files
------------

// File: rtl/switches_pkg.sv
// switches_pkg: register offsets and interrupt FSM states shared by the switches_port files
package switches_pkg;
  localparam int STABLE_OFF = 0;
  typedef enum logic [1:0] {IDLE, REQ, SERVICED} irq_state_e;
  function automatic int change_off(input int num_bytes);
    return num_bytes;
  endfunction
  function automatic int irq_en_off(input int num_bytes);
    return num_bytes + 1;
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: one switch byte, synchroniser plus debounced STABLE (counter present only with SWITCHES_DEBOUNCE_EN)
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pin,
  output logic [7:0] stable,
  output logic       commit
);
  logic [7:0] s1, s2;
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("switch_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
`ifdef SWITCHES_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;
  logic settling;
  // s1 is the value S takes next cycle, so s1 != s2 marks the cycle in which S moves;
  // counting from the first cycle S shows a new value makes pin-to-STABLE 2 + DEBOUNCE_CYCLES
  assign settling = s2 != stable && s2 == s1;
  assign commit = settling && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // synchronise, count consecutive settled cycles, commit S once the count completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      cnt <= settling && !commit ? cnt + 1'b1 : '0;
      if (commit) stable <= s2;
    end
  end
`else
  assign commit = s2 != stable;
  // synchronise and follow S directly, one cycle behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      stable <= s2;
    end
  end
`endif
endmodule

// File: rtl/switches_port.sv
// switches_port: bus-mapped switch banks with sticky change flags and an acknowledged interrupt (debounce via SWITCHES_DEBOUNCE_EN)
module switches_port
  import switches_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hE0,
  parameter int NUM_BYTES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  inout  wire  [7:0]             BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  input  logic [8*NUM_BYTES-1:0] SW,
  output logic                   BUS_INTERRUPT_RAISE,
  input  logic                   BUS_INTERRUPT_ACK
);
  localparam logic [7:0] CHG = 8'(change_off(NUM_BYTES));
  localparam logic [7:0] IEN = 8'(irq_en_off(NUM_BYTES));
  localparam logic [7:0] WIN = 8'(NUM_BYTES + 2);
  logic [NUM_BYTES-1:0][7:0] stable;
  logic [NUM_BYTES-1:0] commit;
  logic [7:0] off, rd, rd_q, change, irq_en;
  logic drv, pending;
  irq_state_e state, state_n;
  assign off = BUS_ADDR - BASE_ADDR;
  assign pending = |(change & irq_en);
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_bank
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk(CLK),
      .rst_n(RESET),
      .pin(SW[8*i+:8]),
      .stable(stable[i]),
      .commit(commit[i])
    );
  end
  // register read mux
  always_comb begin
    rd = off == CHG ? change : off == IEN ? irq_en : 8'h00;
    for (int b = 0; b < NUM_BYTES; b++) rd = off == 8'(STABLE_OFF + b) ? stable[b] : rd;
  end
  // registered read data and drive enable, one cycle of read latency
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      drv <= 1'b0;
      rd_q <= '0;
    end else begin
      drv <= off < WIN && !BUS_WE;
      rd_q <= rd;
    end
  end
  assign BUS_DATA = drv && !BUS_WE ? rd_q : 'z;
  // sticky change flags (a commit beats a same-cycle clear) and interrupt mask
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      change <= '0;
      irq_en <= '0;
    end else begin
      change <= (change & ~(BUS_WE && off == CHG ? BUS_DATA : 8'h00)) | 8'(commit);
      irq_en <= BUS_WE && off == IEN ? BUS_DATA : irq_en;
    end
  end
  // interrupt state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else state <= state_n;
  end
  // interrupt next state: raise once, stay quiet after ack until all enabled flags clear
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pending ? REQ : IDLE;
      REQ:     state_n = BUS_INTERRUPT_ACK ? SERVICED : REQ;
      default: state_n = pending ? SERVICED : IDLE;
    endcase
  end
  assign BUS_INTERRUPT_RAISE = state == REQ;
endmodule

// File: tb/tb_switches_port.sv
// tb_switches_port: randomized self-checking bench for switches_port against a window-based reference model
module tb_switches_port;
  localparam int NB = 2;
  localparam int D = 8;
  localparam logic [7:0] BASE = 8'hE0;
`ifdef SWITCHES_DEBOUNCE_EN
  localparam int LAT = 2 + D + 1;
`else
  localparam int LAT = 3 + 1;
`endif
  logic clk = 0, rst_n = 0, we = 0, ack = 0, raise;
  logic [7:0] addr = BASE, cpu_data = 0;
  logic [15:0] sw = 0;
  tri1 [7:0] bus_data;
  assign bus_data = we ? cpu_data : 8'bz;
  always #5 clk = ~clk;
  switches_port #(.BASE_ADDR(BASE), .NUM_BYTES(NB), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(addr), .BUS_WE(we),
    .SW(sw), .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack)
  );
  int n_tests = 0, n_fail = 0;
  logic [15:0] q[$];
  logic [7:0] m_st[NB];
  logic [7:0] m_chg, m_ien, m_rq;
  logic m_rv, m_raised, m_serv;

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    logic [7:0] d;
    int o;
    d = a - BASE;
    o = int'(d);
    if (o < NB) return m_st[o];
    if (o == NB) return m_chg;
    if (o == NB + 1) return m_ien;
    return 8'h00;
  endfunction

  // an undriven bus floats high through the tri1 net
  function automatic logic [7:0] exp_bus();
    return we ? cpu_data : m_rv ? m_rq : 8'hFF;
  endfunction

  task automatic m_reset();
    q.delete();
    repeat (D + 4) q.push_back('0);
    foreach (m_st[b]) m_st[b] = '0;
    m_chg = 0; m_ien = 0; m_rq = 0; m_rv = 0; m_raised = 0; m_serv = 0;
  endtask

  // a byte commits when its last D+1 pin samples agree and differ from STABLE
  task automatic m_edge();
    logic [7:0] d, cm, clr, v;
    logic [15:0] t;
    logic pend, same;
    d = addr - BASE;
    cm = 0; clr = 0;
    pend = |(m_chg & m_ien);
    m_rv = int'(d) < NB + 2 && !we;
    if (m_rv) m_rq = m_reg(addr);
    for (int b = 0; b < NB; b++) begin
`ifdef SWITCHES_DEBOUNCE_EN
      t = q[q.size() - 1];
      v = t[8*b+:8];
      same = 1;
      for (int j = 0; j <= D; j++) begin
        t = q[q.size() - 1 - j];
        if (t[8*b+:8] != v) same = 0;
      end
      if (same && v != m_st[b]) begin
        cm[b] = 1;
        m_st[b] = v;
      end
`else
      t = q[q.size() - 2];
      v = t[8*b+:8];
      same = v != m_st[b];
      if (same) cm[b] = 1;
      m_st[b] = v;
`endif
    end
    if (we && int'(d) == NB) clr = cpu_data;
    if (we && int'(d) == NB + 1) m_ien = cpu_data;
    m_chg = (m_chg & ~clr) | cm;
    if (m_raised) begin
      if (ack) begin m_raised = 0; m_serv = 1; end
    end else if (m_serv) begin
      if (!pend) m_serv = 0;
    end else if (pend) m_raised = 1;
    q.push_back(sw);
    if (q.size() > 32) void'(q.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] want[3];
    want = '{8'h5A, 8'hA5, 8'h03};
    sw = 16'hA55A; rst_n = 0; we = 0; addr = BASE;
    m_reset();
    repeat (3) begin
      cycle();
      n_tests++;
      if (bus_data !== 8'hFF || raise !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: bus=%h raise=%b want bus=ff raise=0", bus_data, raise);
      end
    end
    rst_n = 1;
    repeat (2 + D) cycle();
    for (int k = 0; k < 3; k++) begin
      addr = BASE + 8'(k);
      cycle();
      n_tests++;
      if (bus_data !== want[k]) begin
        n_fail++;
        $display("FAIL reset_initial_read %0d: got %h want %h", k, bus_data, want[k]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] old, nv;
    int first;
    we = 1; addr = BASE + 8'(NB); cpu_data = 8'hFF;
    cycle();
    we = 0; addr = BASE;
    old = sw[7:0];
    sw[0] = ~sw[0];
    for (int i = 0; i < 25; i++) begin
      if (i == 5) sw[0] = ~sw[0];
      cycle();
      n_tests++;
      if (bus_data !== exp_bus()) begin
        n_fail++;
        $display("FAIL glitch_read: got %h want %h", bus_data, exp_bus());
      end
    end
    n_tests++;
    if (bus_data !== old) begin
      n_fail++;
      $display("FAIL glitch_stable: got %h want %h", bus_data, old);
    end
    addr = BASE + 8'(NB);
    cycle();
    n_tests++;
`ifdef SWITCHES_DEBOUNCE_EN
    if (bus_data !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch_change: got %h want 00", bus_data);
    end
`else
    if (bus_data[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_change: got %h want bit0 set", bus_data);
    end
`endif
    addr = BASE;
    nv = old ^ 8'h01;
    sw[7:0] = nv;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first == 0 && bus_data === nv) first = i;
      if (i == 10) sw[7:0] = old;
      n_tests++;
      if (bus_data !== exp_bus()) begin
        n_fail++;
        $display("FAIL hold_read: got %h want %h", bus_data, exp_bus());
      end
    end
    n_tests++;
    if (first != LAT) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d want %0d", first, LAT);
    end
  endtask

  task automatic wait_raise(input string name);
    int hit;
    hit = 0;
    for (int i = 0; i < 60 && hit == 0; i++) begin
      cycle();
      n_tests++;
      if (raise !== m_raised) begin
        n_fail++;
        $display("FAIL %s_raise: got %b want %b", name, raise, m_raised);
      end
      if (raise === 1'b1) hit = 1;
    end
    n_tests++;
    if (hit == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: raise got 0 want 1 within 60 cycles", name);
    end
  endtask

  task automatic test_irq();
    we = 1; addr = BASE + 8'(NB + 1); cpu_data = 8'h02;
    cycle();
    we = 0; addr = BASE + 8'd9;
    sw[15:8] = sw[15:8] ^ 8'($urandom_range(1, 255));
    wait_raise("irq_first");
    ack = 1;
    cycle();
    ack = 0;
    n_tests++;
    if (raise !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_ack: raise got %b want 0", raise);
    end
    sw[15:8] = sw[15:8] ^ 8'($urandom_range(1, 255));
    repeat (LAT + 4) begin
      cycle();
      n_tests++;
      if (raise !== 1'b0 || m_raised !== 1'b0) begin
        n_fail++;
        $display("FAIL irq_serviced_quiet: raise got %b want 0", raise);
      end
    end
    we = 1; addr = BASE + 8'(NB); cpu_data = 8'h02;
    cycle();
    we = 0; addr = BASE + 8'd9;
    cycle();
    n_tests++;
    if (raise !== m_raised) begin
      n_fail++;
      $display("FAIL irq_clear: raise got %b want %b", raise, m_raised);
    end
    sw[15:8] = sw[15:8] ^ 8'($urandom_range(1, 255));
    wait_raise("irq_again");
    ack = 1;
    cycle();
    ack = 0; we = 1; addr = BASE + 8'(NB); cpu_data = 8'hFF;
    cycle();
    we = 0; addr = BASE + 8'd9;
    cycle();
  endtask

  task automatic test_set_wins();
    we = 1; addr = BASE + 8'(NB); cpu_data = 8'hFF;
    cycle();
    we = 0; addr = BASE + 8'd9;
    sw[7:0] = sw[7:0] ^ 8'h3C;
    repeat (LAT - 2) cycle();
    we = 1; addr = BASE + 8'(NB); cpu_data = 8'h01;
    cycle();
    we = 0;
    cycle();
    n_tests++;
    if (bus_data[0] !== 1'b1 || bus_data !== exp_bus()) begin
      n_fail++;
      $display("FAIL set_wins: got %h want %h with bit0 set", bus_data, exp_bus());
    end
  endtask

  task automatic test_window();
    logic [7:0] v;
    we = 0; addr = BASE + 8'(NB + 2);
    cycle();
    n_tests++;
    if (bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL window_out: got %h want ff (released)", bus_data);
    end
    addr = BASE;
    cycle();
    we = 1; cpu_data = ~exp_bus();
    #1;
    n_tests++;
    if (bus_data !== cpu_data) begin
      n_fail++;
      $display("FAIL write_no_drive: got %h want %h", bus_data, cpu_data);
    end
    cycle();
    we = 0; addr = BASE + 8'd9;
    #1;
    n_tests++;
    if (bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL after_write: got %h want ff (released)", bus_data);
    end
    repeat (4) begin
      v = 8'($urandom);
      we = 1; addr = BASE + 8'(NB + 1); cpu_data = v;
      cycle();
      we = 0;
      cycle();
      n_tests++;
      if (bus_data !== v) begin
        n_fail++;
        $display("FAIL irq_en_read: got %h want %h", bus_data, v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] nv;
    int first;
    we = 1; addr = BASE + 8'(NB + 1); cpu_data = 8'hFF;
    cycle();
    we = 0; addr = BASE + 8'd9;
    sw[15:8] = sw[15:8] ^ 8'($urandom_range(1, 255));
    wait_raise("mid_req");
    sw[7:0] = sw[7:0] ^ 8'h81;
    repeat (4) cycle();
    addr = BASE;
    cycle();
    rst_n = 0;
    m_reset();
    #1;
    n_tests++;
    if (raise !== 1'b0 || bus_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_reset: raise=%b bus=%h want raise=0 bus=ff", raise, bus_data);
    end
    repeat (2) cycle();
    nv = 8'($urandom_range(1, 255));
    sw[7:0] = nv;
    rst_n = 1;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (first == 0 && bus_data === nv) first = i;
      n_tests++;
      if (bus_data !== exp_bus() || raise !== m_raised) begin
        n_fail++;
        $display("FAIL mid_after: bus=%h raise=%b want bus=%h raise=%b", bus_data, raise, exp_bus(), m_raised);
      end
    end
    n_tests++;
    if (first != LAT) begin
      n_fail++;
      $display("FAIL mid_restart_latency: got %0d want %0d", first, LAT);
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      if ($urandom_range(0, 11) == 0) sw = 16'($urandom);
      we = $urandom_range(0, 7) == 0;
      addr = BASE + 8'($urandom_range(0, 5));
      cpu_data = 8'($urandom);
      ack = raise && $urandom_range(0, 3) == 0;
      cycle();
      n_tests++;
      if (bus_data !== exp_bus() || raise !== m_raised) begin
        n_fail++;
        $display("FAIL random: bus=%h raise=%b want bus=%h raise=%b", bus_data, raise, exp_bus(), m_raised);
      end
    end
    we = 0; ack = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_glitch();
    test_irq();
    test_set_wins();
    test_window();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end
endmodule
